// File: rtl/bus_master_port_if.sv
// Client request/response and serial system-bus signals of one master port.
interface bus_master_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  breq;
   logic                  bgrant;
   logic                  mode;
   logic                  wr_bus;
   logic                  master_valid;
   logic                  slave_ready;
   logic                  rd_bus;
   logic                  slave_valid;
   logic                  master_ready;
   logic                  ack;
   logic                  split;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  bgrant, slave_ready, rd_bus, slave_valid, ack, split,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
      output breq, mode, wr_bus, master_valid, master_ready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output bgrant, slave_ready, rd_bus, slave_valid, ack, split,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
      input  breq, mode, wr_bus, master_valid, master_ready
   );
endinterface

// File: rtl/bus_master_port.sv
// Master-side serial bus port: one parallel request in, serial
// address then write/read data out over the arbitrated 1-bit bus.
module bus_master_port #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int SEL_BITS   = 5
) (
   input logic          clk,
   input logic          rstn,
   bus_master_if.master bus
);
   localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW   = $clog2(MAXW) + 1;
   localparam logic [CW-1:0] SEL_LAST  = CW'(SEL_BITS - 1);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, REQ, ADDR, ACK_CHK, WDATA, RDATA, DONE, SPLIT_WAIT
   } state_t;

   state_t state_q, state_d, resume_q, resume_d, nom;
   logic                  wr_q, err_q;
   logic [ADDR_WIDTH-1:0] addr_sh;
   logic [DATA_WIDTH-1:0] dat_sh, rdata_q;
   logic [CW-1:0]         cnt_q;
   logic breq_c, mval_c, mrdy_c, wbit_c;
   logic mv_w, mv_r, accept;

   assign accept = (state_q == IDLE) && bus.req_valid;
   assign mv_w   = mval_c && bus.slave_ready;
   assign mv_r   = mrdy_c && bus.slave_valid;

   always_comb begin
      state_d  = state_q;
      resume_d = resume_q;
      nom      = state_q;
      breq_c   = 1'b0;
      mval_c   = 1'b0;
      mrdy_c   = 1'b0;
      wbit_c   = 1'b0;
      unique case (state_q)
         IDLE: if (bus.req_valid) state_d = REQ;
         REQ: begin
            breq_c = 1'b1;
            if (bus.bgrant) state_d = ADDR;
         end
         ADDR: begin
            breq_c = 1'b1;
            mval_c = bus.bgrant;
            wbit_c = addr_sh[ADDR_WIDTH-1];
            if (mval_c && bus.slave_ready) begin
               if (cnt_q == SEL_LAST) nom = ACK_CHK;
               else if (cnt_q == ADDR_LAST) nom = wr_q ? WDATA : RDATA;
            end
         end
         ACK_CHK: begin
            breq_c  = 1'b1;
            state_d = bus.ack ? ADDR : DONE;
         end
         WDATA: begin
            breq_c = 1'b1;
            mval_c = bus.bgrant;
            wbit_c = dat_sh[DATA_WIDTH-1];
            if (mval_c && bus.slave_ready && cnt_q == DATA_LAST) nom = DONE;
         end
         RDATA: begin
            breq_c = 1'b1;
            mrdy_c = bus.bgrant;
            if (mrdy_c && bus.slave_valid && cnt_q == DATA_LAST) nom = DONE;
         end
         DONE: state_d = IDLE;
         SPLIT_WAIT: if (!bus.split && bus.bgrant) state_d = resume_q;
      endcase
      // a bit moved together with split still counts; a finished phase ignores split
      if (state_q inside {ADDR, WDATA, RDATA}) begin
         if (bus.split && nom != DONE) begin
            state_d  = SPLIT_WAIT;
            resume_d = nom;
         end else begin
            state_d = nom;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         resume_q <= IDLE;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_sh  <= '0;
         dat_sh   <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         if (accept) begin
            wr_q    <= bus.req_write;
            addr_sh <= bus.req_addr;
            dat_sh  <= bus.req_wdata;
            cnt_q   <= '0;
            err_q   <= 1'b0;
         end
         if (state_q == ACK_CHK && !bus.ack) err_q <= 1'b1;
         if (mv_w && state_q == ADDR) begin
            addr_sh <= addr_sh << 1;
            cnt_q   <= (cnt_q == ADDR_LAST) ? '0 : cnt_q + CW'(1);
         end
         if (mv_w && state_q == WDATA) begin
            dat_sh <= dat_sh << 1;
            cnt_q  <= (cnt_q == DATA_LAST) ? '0 : cnt_q + CW'(1);
         end
         if (mv_r) begin
            dat_sh <= {dat_sh[DATA_WIDTH-2:0], bus.rd_bus};
            cnt_q  <= (cnt_q == DATA_LAST) ? '0 : cnt_q + CW'(1);
            if (cnt_q == DATA_LAST)
               rdata_q <= {dat_sh[DATA_WIDTH-2:0], bus.rd_bus};
         end
      end
   end

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.rsp_valid    = (state_q == DONE);
   assign bus.rsp_err      = (state_q == DONE) && err_q;
   assign bus.rsp_rdata    = rdata_q;
   assign bus.breq         = breq_c;
   assign bus.mode         = (state_q != IDLE) && wr_q;
   assign bus.wr_bus       = wbit_c;
   assign bus.master_valid = mval_c;
   assign bus.master_ready = mrdy_c;
endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed scenarios plus
// randomized transactions against a bit-stream reference model.
module tb_bus_master_port;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   bus_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

   bus_master_port #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(8),
      .SEL_BITS  (5)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // slave-side observer: owns the moved-bit queues and counters
   int   txn_id  = 0;
   int   seen_id = 0;
   bit   wq[$];
   bit   rq[$];
   int   mode_cnt, mr_cnt, mr_early, unstable;
   bit   hold_pend;
   logic hold_bit;

   always @(posedge clk) begin
      if (txn_id != seen_id) begin
         seen_id = txn_id;
         wq.delete();
         rq.delete();
         mode_cnt  = 0;
         mr_cnt    = 0;
         mr_early  = 0;
         unstable  = 0;
         hold_pend = 1'b0;
      end
      if (rstn) begin
         if (hold_pend && bus.master_valid && (bus.wr_bus !== hold_bit))
            unstable++;
         hold_pend = bus.master_valid && !bus.slave_ready;
         hold_bit  = bus.wr_bus;
         if (bus.mode) mode_cnt++;
         if (bus.master_ready) begin
            mr_cnt++;
            if (wq.size() != 16) mr_early++;
         end
         if (bus.master_valid && bus.slave_ready) wq.push_back(bus.wr_bus);
         if (bus.master_ready && bus.slave_valid) rq.push_back(bus.rd_bus);
      end
   end

   logic [7:0] model_rdata = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req_valid   = 1'b0;
      bus.req_write   = 1'b0;
      bus.req_addr    = '0;
      bus.req_wdata   = '0;
      bus.bgrant      = 1'b0;
      bus.slave_ready = 1'b0;
      bus.rd_bus      = 1'b0;
      bus.slave_valid = 1'b0;
      bus.ack         = 1'b0;
      bus.split       = 1'b0;
   endtask

   task automatic start(input logic w, input logic [15:0] a,
                        input logic [7:0] d);
      chk("req_ready_idle", bus.req_ready, 1);
      txn_id++;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic run_txn(input int pr, input int pv, input int pg,
                          input int ps, output int lat);
      bit done;
      done = 1'b0;
      lat  = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         bus.slave_ready = ($urandom_range(0, 99) < pr);
         bus.slave_valid = ($urandom_range(0, 99) < pv);
         bus.bgrant      = ($urandom_range(0, 99) < pg);
         bus.split       = ($urandom_range(0, 99) < ps);
         bus.rd_bus      = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1 lat++;
         if (bus.rsp_valid) done = 1'b1;
      end
      bus.split = 1'b0;
      chk("txn_done", done, 1);
   endtask

   // expected stream: address MSB-first (only the select field on a
   // refused address), then write data; read data is what the slave fed
   task automatic verify(input string tag, input logic w,
                         input logic [15:0] a, input logic [7:0] d,
                         input logic ak);
      int         exp_n;
      logic [23:0] obs, exp_s;
      logic [7:0]  rd;
      exp_n = !ak ? 5 : (w ? 24 : 16);
      chk({tag, "_nbits"}, wq.size(), exp_n);
      obs = '0;
      foreach (wq[i]) obs = {obs[22:0], wq[i]};
      exp_s = !ak ? {19'd0, a[15:11]} : (w ? {a, d} : {8'd0, a});
      chk({tag, "_stream"}, obs, exp_s);
      chk({tag, "_rbits"}, rq.size(), (!w && ak) ? 8 : 0);
      if (!w && ak) begin
         rd = '0;
         foreach (rq[i]) rd = {rd[6:0], rq[i]};
         model_rdata = rd;
      end
      chk({tag, "_rdata"}, bus.rsp_rdata, model_rdata);
      chk({tag, "_err"}, bus.rsp_err, !ak);
      chk({tag, "_breq_done"}, bus.breq, 0);
      @(posedge clk);
      #1;
      chk({tag, "_idle_after"}, {bus.req_ready, bus.breq, bus.rsp_valid,
                                 bus.master_valid}, 4'b1000);
   endtask

   initial begin
      int         lat;
      bit         tog, ok;
      logic [7:0] pat;
      logic       w, ak;
      logic [15:0] a;
      logic [7:0]  d;

      idle_inputs();
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1;
      chk("rst_outs", {bus.breq, bus.master_valid, bus.master_ready, bus.mode,
                       bus.wr_bus, bus.rsp_valid, bus.rsp_err}, 0);
      chk("rst_rdata", bus.rsp_rdata, 0);
      chk("rst_ready", bus.req_ready, 1);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // write 0x1234 <- 0xA5, no stalls
      start(1'b1, 16'h1234, 8'hA5);
      bus.ack = 1'b1;
      run_txn(100, 100, 100, 0, lat);
      chk("wr_latency", lat, 26);
      verify("wr1234", 1'b1, 16'h1234, 8'hA5, 1'b1);

      // read 0x0800 with rd_bus pattern 1100_0011
      pat = 8'hC3;
      start(1'b0, 16'h0800, 8'h00);
      bus.ack = 1'b1; bus.bgrant = 1'b1;
      bus.slave_ready = 1'b1; bus.slave_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         bus.rd_bus = (rq.size() < 8) ? pat[7 - rq.size()] : 1'b0;
         @(posedge clk);
         #1 if (bus.rsp_valid) ok = 1'b1;
      end
      chk("rd_done", ok, 1);
      chk("rd_rdata_c3", bus.rsp_rdata, 8'hC3);
      chk("rd_mode", mode_cnt, 0);
      chk("rd_mready_cycles", mr_cnt, 8);
      chk("rd_mready_early", mr_early, 0);
      verify("rd0800", 1'b0, 16'h0800, 8'h00, 1'b1);

      // refused select field
      start(1'b1, 16'hF800, 8'h3C);
      bus.ack = 1'b0;
      run_txn(100, 100, 100, 0, lat);
      chk("nak_latency", lat, 7);
      verify("nak", 1'b1, 16'hF800, 8'h3C, 1'b0);

      // split after 3 of 8 read bits
      pat = 8'h5A;
      start(1'b0, 16'h0A11, 8'h00);
      bus.ack = 1'b1; bus.bgrant = 1'b1;
      bus.slave_ready = 1'b1; bus.slave_valid = 1'b1;
      for (int i = 0; i < 100 && rq.size() < 3; i++) begin
         bus.rd_bus = pat[7 - rq.size()];
         @(posedge clk);
         #1;
      end
      bus.split = 1'b1; bus.slave_valid = 1'b0; bus.bgrant = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("split_breq", {bus.breq, bus.master_ready}, 2'b00);
      chk("split_hold", rq.size(), 3);
      bus.split = 1'b0; bus.bgrant = 1'b1; bus.slave_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         bus.rd_bus = (rq.size() < 8) ? pat[7 - rq.size()] : 1'b0;
         @(posedge clk);
         #1 if (bus.rsp_valid) ok = 1'b1;
      end
      chk("split_done", ok, 1);
      chk("split_rdata", bus.rsp_rdata, 8'h5A);
      verify("split", 1'b0, 16'h0A11, 8'h00, 1'b1);

      // slave_ready toggling during write data
      start(1'b1, 16'h4321, 8'h96);
      bus.ack = 1'b1; bus.bgrant = 1'b1;
      tog = 1'b1; ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (wq.size() < 16) bus.slave_ready = 1'b1;
         else begin
            bus.slave_ready = tog;
            tog = ~tog;
         end
         @(posedge clk);
         #1 if (bus.rsp_valid) ok = 1'b1;
      end
      chk("tog_done", ok, 1);
      chk("tog_stable", unstable, 0);
      verify("tog", 1'b1, 16'h4321, 8'h96, 1'b1);

      // asynchronous reset mid write data
      start(1'b1, 16'h1357, 8'hE1);
      bus.ack = 1'b1; bus.bgrant = 1'b1; bus.slave_ready = 1'b1;
      for (int i = 0; i < 100 && wq.size() < 19; i++) begin
         @(posedge clk);
         #1;
      end
      chk("mid_wdata", wq.size(), 19);
      #2 rstn = 1'b0;
      #1;
      chk("arst_outs", {bus.breq, bus.master_valid, bus.master_ready, bus.mode,
                        bus.wr_bus, bus.rsp_valid, bus.rsp_err}, 0);
      chk("arst_rdata", bus.rsp_rdata, 0);
      chk("arst_ready", bus.req_ready, 1);
      model_rdata = 8'h00;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1 chk("rel_ready", bus.req_ready, 1);
      start(1'b1, 16'h2468, 8'h7E);
      bus.ack = 1'b1;
      run_txn(100, 100, 100, 0, lat);
      chk("post_rst_latency", lat, 26);
      verify("post_rst", 1'b1, 16'h2468, 8'h7E, 1'b1);

      // randomized traffic with stalls, splits and refusals
      for (int n = 0; n < 20; n++) begin
         w  = 1'($urandom_range(0, 1));
         a  = 16'($urandom);
         d  = 8'($urandom);
         ak = ($urandom_range(0, 9) < 8);
         start(w, a, d);
         bus.ack = ak;
         run_txn(70, 70, 85, 5, lat);
         verify("rnd", w, a, d, ak);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
